// File: rtl/knn_sort_ctrl.sv
// knn_sort_ctrl: sequencer for the 8-entry two-nearest sort tree.
// Collects up to 8 (distance, label) pairs into a bank that drives the sort
// tree D inputs. Short queries are padded with all-ones distances so unused
// slots cannot win. After the tree latency it captures the two smallest
// addresses, looks up their labels and holds one result per query on a
// valid/ready interface.
// Ports:
//   clk, rst                      clock, async active-high reset
//   dist_valid/ready/in/last      input pair stream, lbl_in is the pair label
//   sort_D                        distance bank to sort tree
//   sort_addr1/2                  sort tree nearest / runner-up addresses
//   res_valid/ready               result handshake
//   res_addr1/2, res_label1/2     captured addresses and their labels
//   res_match                     both labels equal
//   res_pad_hit                   bit i set if addr i selects a padded slot
module knn_sort_ctrl #(
  parameter int unsigned Bit      = 8,
  parameter int unsigned LBL_W    = 2,
  parameter int unsigned SORT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dist_valid,
  output logic             dist_ready,
  input  logic [Bit-1:0]   dist_in,
  input  logic [LBL_W-1:0] lbl_in,
  input  logic             dist_last,
  output logic [Bit-1:0]   sort_D [7:0],
  input  logic [2:0]       sort_addr1,
  input  logic [2:0]       sort_addr2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_addr1,
  output logic [2:0]       res_addr2,
  output logic [LBL_W-1:0] res_label1,
  output logic [LBL_W-1:0] res_label2,
  output logic             res_match,
  output logic [1:0]       res_pad_hit
);

  localparam int unsigned WaitW = $clog2(SORT_LAT + 2);

  typedef enum logic [1:0] {StLoad, StWait, StOut} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [Bit-1:0]   bank_q [7:0];
  logic [Bit-1:0]   bank_d [7:0];
  logic [LBL_W-1:0] lbl_q [7:0];
  logic [LBL_W-1:0] lbl_d [7:0];
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       addr1_q, addr1_d, addr2_q, addr2_d;
  logic [LBL_W-1:0] label1_q, label1_d, label2_q, label2_d;
  logic             match_q, match_d;
  logic [1:0]       pad_q, pad_d;
  logic             accept;

  // Ready is masked by rst so nothing is offered while reset is held.
  assign dist_ready = (state_q == StLoad) && !rst;
  assign accept     = dist_valid && dist_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    bank_d   = bank_q;
    lbl_d    = lbl_q;
    mask_d   = mask_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    label1_d = label1_q;
    label2_d = label2_q;
    match_d  = match_q;
    pad_d    = pad_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          bank_d[cnt_q] = dist_in;
          lbl_d[cnt_q]  = lbl_in;
          mask_d[cnt_q] = 1'b1;
          cnt_d         = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = StWait;
            wait_d  = WaitW'(SORT_LAT);
          end else if (dist_last) begin
            // Pad the remaining slots with the maximum distance.
            for (int i = 0; i < 8; i++) begin
              if (3'(i) > cnt_q) begin
                bank_d[i] = '1;
                lbl_d[i]  = '0;
                mask_d[i] = 1'b0;
              end
            end
            state_d = StWait;
            wait_d  = WaitW'(SORT_LAT);
          end
        end
      end
      StWait: begin
        if (wait_q == '0) begin
          addr1_d  = sort_addr1;
          addr2_d  = sort_addr2;
          label1_d = lbl_q[sort_addr1];
          label2_d = lbl_q[sort_addr2];
          match_d  = (lbl_q[sort_addr1] == lbl_q[sort_addr2]);
          pad_d    = {~mask_q[sort_addr2], ~mask_q[sort_addr1]};
          state_d  = StOut;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StOut: begin
        if (res_ready) begin
          state_d = StLoad;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      wait_q   <= '0;
      mask_q   <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      label1_q <= '0;
      label2_q <= '0;
      match_q  <= 1'b0;
      pad_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= '0;
        lbl_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      mask_q   <= mask_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      label1_q <= label1_d;
      label2_q <= label2_d;
      match_q  <= match_d;
      pad_q    <= pad_d;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= bank_d[i];
        lbl_q[i]  <= lbl_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) sort_D[i] = bank_q[i];
  end

  assign res_valid   = (state_q == StOut);
  assign res_addr1   = addr1_q;
  assign res_addr2   = addr2_q;
  assign res_label1  = label1_q;
  assign res_label2  = label2_q;
  assign res_match   = match_q;
  assign res_pad_hit = pad_q;

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Directed bench for knn_sort_ctrl with a registered two-smallest tree model.
module tb_knn_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dist_valid, dist_last, res_ready;
  logic       dist_ready, res_valid, res_match;
  logic [7:0] dist_in;
  logic [1:0] lbl_in, res_label1, res_label2, res_pad_hit;
  logic [7:0] sort_D [7:0];
  logic [2:0] sort_addr1, sort_addr2, res_addr1, res_addr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  knn_sort_ctrl #(.Bit(8), .LBL_W(2), .SORT_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .dist_valid (dist_valid),
    .dist_ready (dist_ready),
    .dist_in    (dist_in),
    .lbl_in     (lbl_in),
    .dist_last  (dist_last),
    .sort_D     (sort_D),
    .sort_addr1 (sort_addr1),
    .sort_addr2 (sort_addr2),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_addr1  (res_addr1),
    .res_addr2  (res_addr2),
    .res_label1 (res_label1),
    .res_label2 (res_label2),
    .res_match  (res_match),
    .res_pad_hit(res_pad_hit)
  );

  // Sort tree stand-in: one register stage, lowest index wins ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sort_addr1 <= '0;
      sort_addr2 <= '0;
    end else begin
      int m1, m2;
      m1 = 0;
      for (int i = 1; i < 8; i++) if (sort_D[i] < sort_D[m1]) m1 = i;
      m2 = (m1 == 0) ? 1 : 0;
      for (int i = 0; i < 8; i++) if (i != m1 && sort_D[i] < sort_D[m2]) m2 = i;
      sort_addr1 <= 3'(m1);
      sort_addr2 <= 3'(m2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] l, input logic last);
    int n;
    n = 0;
    dist_valid = 1'b1;
    dist_in    = d;
    lbl_in     = l;
    dist_last  = last;
    while (!dist_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(dist_ready), 32'd1);
    @(negedge clk);
    dist_valid = 1'b0;
    dist_last  = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [1:0] l1, input logic [1:0] l2, input logic m,
                         input logic [1:0] p);
    chk({tag, "_addr1"}, 32'(res_addr1), 32'(a1));
    chk({tag, "_addr2"}, 32'(res_addr2), 32'(a2));
    chk({tag, "_label1"}, 32'(res_label1), 32'(l1));
    chk({tag, "_label2"}, 32'(res_label2), 32'(l2));
    chk({tag, "_match"}, 32'(res_match), 32'(m));
    chk({tag, "_pad"}, 32'(res_pad_hit), 32'(p));
  endtask

  initial begin
    logic [7:0] d1 [8];
    logic [1:0] l1 [8];
    logic [7:0] d5 [8];
    logic [7:0] d6 [8];
    logic [1:0] l6 [8];
    logic [2:0] a1s, a2s;
    d1 = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd5, 8'd6, 8'd4};
    l1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    d5 = '{8'd50, 8'd40, 8'd2, 8'd60, 8'd70, 8'd1, 8'd90, 8'd80};
    d6 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd6, 8'd7, 8'd8};
    l6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    rst = 1'b1; dist_valid = 1'b0; dist_last = 1'b0; dist_in = '0; lbl_in = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_dist_ready", 32'(dist_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_sort_d7", 32'(sort_D[7]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_dist_ready", 32'(dist_ready), 32'd1);

    // Full query with exact latency check.
    for (int i = 0; i < 8; i++) send(d1[i], l1[i], 1'b0);
    chk("full_ready_low", 32'(dist_ready), 32'd0);
    chk("full_lat_e1", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("full_lat_e2", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("full_lat_valid", 32'(res_valid), 32'd1);
    chk_res("full", 3'd3, 3'd1, 2'd3, 2'd1, 1'b0, 2'b00);
    @(negedge clk);
    chk("full_consumed", 32'(res_valid), 32'd0);

    // Short query: padding fills slots 3..7.
    send(8'd20, 2'd1, 1'b0);
    send(8'd5, 2'd2, 1'b0);
    send(8'd12, 2'd3, 1'b1);
    chk("short_pad3", 32'(sort_D[3]), 32'hFF);
    chk("short_pad7", 32'(sort_D[7]), 32'hFF);
    chk("short_d2", 32'(sort_D[2]), 32'd12);
    wait_res();
    chk_res("short", 3'd1, 3'd2, 2'd2, 2'd3, 1'b0, 2'b00);
    @(negedge clk);

    // Single all-ones entry ties with pads; tree picks 0 then 1.
    send(8'hFF, 2'd1, 1'b1);
    wait_res();
    chk_res("single", 3'd0, 3'd1, 2'd1, 2'd0, 1'b0, 2'b10);
    @(negedge clk);

    // Back-pressure with both winners sharing label 2.
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(d5[i], (i == 2 || i == 5) ? 2'd2 : 2'(i % 2), 1'b0);
    wait_res();
    chk_res("bp", 3'd5, 3'd2, 2'd2, 2'd2, 1'b1, 2'b00);
    a1s = res_addr1;
    a2s = res_addr2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_ready", 32'(dist_ready), 32'd0);
      chk("bp_hold_addr", 32'({res_addr1, res_addr2}), 32'({a1s, a2s}));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_release_ready", 32'(dist_ready), 32'd1);
    res_ready = 1'b1;

    // Reset mid-query, then an independent full query.
    for (int i = 0; i < 4; i++) send(8'd100 + 8'(i), 2'd3, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(dist_ready), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_d0", 32'(sort_D[0]), 32'd0);
    chk("midrst_addr1", 32'(res_addr1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(d6[i], l6[i], 1'b0);
    wait_res();
    chk_res("post_rst", 3'd4, 3'd5, 2'd3, 2'd2, 1'b0, 2'b00);
    @(negedge clk);
    chk("post_rst_done", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_sort_ctrl.md
Name: knn_sort_ctrl

Overview:
Sequencer for the 8-entry two-nearest sort tree in the kNN classifier datapath. It accepts a stream of up to 8 (distance, label) pairs and holds them in a register bank that drives the sort tree's D inputs. It waits out the tree's latency, captures the two smallest addresses, looks up their labels, and presents one result per query on a valid/ready interface. It also pads short queries so unused slots cannot win.

Parameters:
Bit, 8, distance width; must match the sort tree instance's Bit
LBL_W, 2, class-label width
SORT_LAT, 1, cycles from the final bank write until the sort tree's registered address outputs are valid (1 for the current unpipelined tree)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
dist_valid  in  1  input pair valid
dist_ready  out  1  controller can accept a pair
dist_in  in  Bit  distance value
lbl_in  in  LBL_W  class label of this training point
dist_last  in  1  final pair of the query
sort_D  out  Bit x 8 (unpacked [7:0])  distance bank, drives sort tree D
sort_addr1  in  3  sort tree smallest_addr1 (nearest)
sort_addr2  in  3  sort tree smallest_addr2 (runner-up)
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_addr1  out  3  nearest entry index
res_addr2  out  3  second-nearest entry index
res_label1  out  LBL_W  label of res_addr1
res_label2  out  LBL_W  label of res_addr2
res_match  out  1  res_label1 == res_label2
res_pad_hit  out  2  bit0/bit1 set if addr1/addr2 selects a padded slot

Behaviour:
- Reset (async, rst=1): state LOAD, load count 0, wait counter 0, bank and labels 0, valid mask 0. Outputs: res_valid 0, dist_ready 0 during reset, all res_* 0, sort_D all 0.
- States: LOAD, WAIT, OUT.
- LOAD: dist_ready=1. A handshake is dist_valid&&dist_ready at a clk edge. Each handshake writes bank[cnt]=dist_in, label[cnt]=lbl_in, mask[cnt]=1, then cnt++.
  - On the handshake with cnt==7, go to WAIT. dist_last is ignored in this case.
  - On a handshake with dist_last=1 and cnt<7, the same edge fills every slot cnt+1..7 with distance all-ones, label 0, mask 0, then goes to WAIT.
- WAIT: dist_ready=0. The wait counter is loaded with SORT_LAT on WAIT entry and decrements once per edge.
  - At the first edge where the counter is 0, capture res_addr1/2=sort_addr1/2 and res_label1/2=label[addr].
  - The same edge sets res_match, sets res_pad_hit[i]=~mask[addr_i], and goes to OUT.
  - Net timing: capture occurs SORT_LAT+1 edges after the edge writing the final entry. SORT_LAT=1 gives capture 2 edges later.
- OUT: res_valid=1 and all res_* stable until res_valid&&res_ready.
  - On that edge, go to LOAD, cnt=0, mask=0, res_valid=0.
  - The bank is not cleared; stale values are overwritten by the next query.
- sort_D changes only on LOAD handshakes. It is constant throughout WAIT and OUT.
- No acceptance in WAIT/OUT. The next query's first pair is accepted no earlier than the edge after the result handshake, so the minimum spacing is one bubble.
- Tie handling: when distances are equal, addresses are taken exactly as the tree reports them; no re-ordering is done here.
- Padding: padded slots use the maximum value. A real entry equal to all-ones may tie with a pad; res_pad_hit reports which slot won.
- Single-entry query (dist_last on the first pair): res_addr1=0 normally, and res_pad_hit[1]=1.
- rst asserted mid-query or mid-OUT: immediate return to the reset state. The partial query and any pending result are discarded.
- dist_in, dist_valid and dist_last are don't-care when dist_ready=0.

Test Plan:
- Full query, SORT_LAT=1, distances {9,3,7,1,8,5,6,4}, labels {0,1,2,3,0,1,2,3}, res_ready=1 -> res_valid 2 edges after the 8th accept; addr1=3, addr2=1, label1=3, label2=1, match=0, pad_hit=00.
- Short query {20,5,12} with dist_last on the 3rd pair -> sort_D[3..7]=0xFF; addr1=1, addr2=2, pad_hit=00.
- Single entry {0xFF}, last -> addr1=0, pad_hit[1]=1.
- Back-pressure: res_ready held 0 for 10 cycles -> res_* stable and dist_ready=0 throughout; after res_ready pulses, dist_ready=1 on the next cycle.
- Labels {2,2,...} with the two smallest sharing label 2 -> res_match=1, label1=label2=2.
- rst pulsed after the 4th accept -> all outputs 0 immediately; the next full 8-pair query produces a correct, independent result.
